// File: rtl/tone_sequencer.sv
// Tone sequencer: steps through a note list held in an external synchronous ROM
// and plays each note as a square wave, with tempo, duty, pause/restart and looping.
module tone_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int ADDR_W      = 7,
    parameter int PERIOD_W    = 20,
    parameter int VOL_BITS    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                play,
    input  logic                restart,
    input  logic                loop_en,
    input  logic [2:0]          speed,
    input  logic [VOL_BITS-1:0] volume,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [PERIOD_W:0]   rom_data,
    output logic                beep,
    output logic                busy,
    output logic [ADDR_W-1:0]   slot,
    output logic                done
);

    localparam int BEAT_W = $clog2(BEAT_CYCLES + 1);
    localparam int HIGH_W = PERIOD_W + VOL_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_PAUSED, S_DONE
    } state_t;

    state_t state, next_state, resume, cur;

    logic [PERIOD_W-1:0] period, tone_cnt;
    logic [HIGH_W-1:0]   high, high_next, prod;
    logic                sound;
    logic [BEAT_W-1:0]   beat_len, beat_cnt, beat_raw, beat_len_next;

    logic end_flag, beat_term, last_addr;
    logic go, run, load_en, song_end, advance;

    assign end_flag  = rom_data[PERIOD_W];
    assign beat_term = (beat_cnt == beat_len - BEAT_W'(1));
    assign last_addr = (rom_addr == {ADDR_W{1'b1}});

    // A paused FSM behaves as the state it left, so resuming costs no extra cycle.
    assign cur = (state == S_PAUSED) ? resume : state;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            resume <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            state <= next_state;
            if (next_state == S_PAUSED)
                resume <= cur;
        end
    end

    // Next-state logic; restart outranks pause and end-of-song.
    always_comb begin
        // NOTE: default first so no path through this block infers a latch.
        next_state = state;
        if (restart) begin
            next_state = S_FETCH;
        end else begin
            case (cur)
                S_IDLE:  if (play) next_state = S_FETCH;
                S_FETCH: next_state = play ? S_LOAD : S_PAUSED;
                S_LOAD: begin
                    if (!play)        next_state = S_PAUSED;
                    else if (end_flag) next_state = loop_en ? S_FETCH : S_DONE;
                    else               next_state = S_PLAY;
                end
                S_PLAY: begin
                    if (!play)          next_state = S_PAUSED;
                    else if (beat_term) next_state = (last_addr && !loop_en) ? S_DONE : S_FETCH;
                end
                default: next_state = state;
            endcase
        end
    end

    // Output / control strobes
    always_comb begin
        busy     = (state != S_IDLE) && (state != S_DONE);
        go       = play && !restart;
        run      = go && (cur == S_PLAY);
        load_en  = go && (cur == S_LOAD) && !end_flag;
        song_end = go && (((cur == S_LOAD) && end_flag) ||
                          ((cur == S_PLAY) && beat_term && last_addr));
        advance  = run && beat_term && !last_addr;
    end

    // Note parameters captured at LOAD: duty threshold and beat length.
    always_comb begin
        prod          = HIGH_W'(rom_data[PERIOD_W-1:0]) * HIGH_W'(volume);
        high_next     = prod >> VOL_BITS;
        beat_raw      = BEAT_W'(BEAT_CYCLES) >> speed;
        beat_len_next = (beat_raw == '0) ? BEAT_W'(1) : beat_raw;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr <= '0;
            slot     <= '0;
            beep     <= 1'b0;
            done     <= 1'b0;
            period   <= '0;
            high     <= '0;
            sound    <= 1'b0;
            beat_len <= '0;
            beat_cnt <= '0;
            tone_cnt <= '0;
        end else begin
            done <= song_end && !loop_en;
            beep <= run && sound && (HIGH_W'(tone_cnt) < high);

            if (restart || (song_end && loop_en))
                rom_addr <= '0;
            else if (advance)
                rom_addr <= rom_addr + ADDR_W'(1);

            if (load_en) begin
                slot     <= rom_addr;
                period   <= rom_data[PERIOD_W-1:0];
                high     <= high_next;
                sound    <= (rom_data[PERIOD_W-1:0] >= PERIOD_W'(2)) && (volume != '0);
                beat_len <= beat_len_next;
                beat_cnt <= '0;
                tone_cnt <= '0;
            end else if (run) begin
                beat_cnt <= beat_term ? '0 : beat_cnt + BEAT_W'(1);
                tone_cnt <= (tone_cnt >= period - PERIOD_W'(1)) ? '0 : tone_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule
